// File: rtl/m_stage_pipe_pkg.sv
// -----------------------------------------------------------------------------
// m_stage_pipe_pkg
// Shared definitions for the Execute->Memory pipeline register:
//   - instruction opcodes used across the pipeline (IROP, IADDI, ILW, ISW, ...)
//   - INOP, the opcode presented on the M side whenever no entry is valid
//   - default widths for the pipe parameters
// -----------------------------------------------------------------------------
package m_stage_pipe_pkg;

  // Default widths.
  localparam int OP_W_DEF   = 6;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int CNT_W_DEF  = 16;

  // Instruction opcodes.
  localparam logic [5:0] IROP  = 6'h00;  // register-register ALU op
  localparam logic [5:0] IJ    = 6'h02;
  localparam logic [5:0] IBEQ  = 6'h04;
  localparam logic [5:0] IBNE  = 6'h05;
  localparam logic [5:0] IADDI = 6'h08;
  localparam logic [5:0] ISLTI = 6'h0A;
  localparam logic [5:0] IANDI = 6'h0C;
  localparam logic [5:0] IORI  = 6'h0D;
  localparam logic [5:0] ILW   = 6'h23;
  localparam logic [5:0] ISW   = 6'h2B;

  // Bubble opcode: M stage treats it as "do nothing".
  localparam logic [5:0] INOP  = 6'h3F;

endpackage

// File: rtl/m_stage_pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One pipeline holding register: a payload word plus its valid bit.
//   clk    : clock, all updates on the rising edge
//   reset  : synchronous active-high, empties the slot
//   load   : capture dIn and mark the slot valid
//   clear  : mark the slot empty (wins over load)
//   dIn    : payload to capture
//   valid  : slot holds an entry
//   dOut   : held payload (only meaningful while valid=1)
// -----------------------------------------------------------------------------
module pipe_slot #(
  parameter int W = 80
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] dIn,
  output logic         valid,
  output logic [W-1:0] dOut
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset)      valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
  end

  // NOTE: the payload is deliberately not reset; it is masked by valid on the
  // way out, so only the valid bit needs a defined reset value.
  always_ff @(posedge clk) begin
    if (load) dOut <= dIn;
  end

endmodule

// File: rtl/m_stage_pipe.sv
// -----------------------------------------------------------------------------
// m_stage_pipe
// Execute->Memory pipeline register with valid/ready flow control.
//   clk, reset      : clock; synchronous active-high reset
//   flush           : synchronous kill of every held entry
//   in_valid/ready  : E-side handshake (accept = in_valid & in_ready)
//   in_op..in_dstM  : E-side payload (op, valE, valA, dstE, dstM)
//   out_valid/ready : M-side handshake (consume = out_valid & out_ready)
//   out_op..out_dstM: M-side payload; a bubble (NOP_OP, zeros) when empty
//   bubble_cnt      : saturating count of edges seen with out_valid=0
// SKID_EN=1 adds a second slot so in_ready is a pure register output;
// SKID_EN=0 keeps one slot with a combinational in_ready.
// -----------------------------------------------------------------------------
module m_stage_pipe
  import m_stage_pipe_pkg::*;
#(
  parameter int              OP_W    = OP_W_DEF,
  parameter int              DATA_W  = DATA_W_DEF,
  parameter int              REG_W   = REG_W_DEF,
  parameter logic [OP_W-1:0] NOP_OP  = OP_W'(INOP),
  parameter int              SKID_EN = 1,
  parameter int              CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [DATA_W-1:0] in_valA,
  input  logic [REG_W-1:0]  in_dstE,
  input  logic [REG_W-1:0]  in_dstM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_valE,
  output logic [DATA_W-1:0] out_valA,
  output logic [REG_W-1:0]  out_dstE,
  output logic [REG_W-1:0]  out_dstM,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valA;
    logic [REG_W-1:0]  dstE;
    logic [REG_W-1:0]  dstM;
  } payload_t;

  localparam int PAY_W = $bits(payload_t);

  payload_t inData;
  payload_t mainIn;
  payload_t mainData;
  payload_t outData;
  logic     mainValid;
  logic     accept;
  logic     consume;
  logic     loadMain;
  logic     clearMain;

  assign inData  = {in_op, in_valE, in_valA, in_dstE, in_dstM};
  assign accept  = in_valid & in_ready;
  assign consume = mainValid & out_ready;

  // Main slot drives the M-side outputs directly: no in_* -> out_* path.
  pipe_slot #(.W(PAY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (loadMain),
    .clear (clearMain),
    .dIn   (mainIn),
    .valid (mainValid),
    .dOut  (mainData)
  );

  if (SKID_EN != 0) begin : g_skid
    logic     skidValid;
    logic     loadSkid;
    logic     clearSkid;
    payload_t skidData;

    // An arrival that cannot go to main (main full and staying full) parks
    // in skid. Skid only ever holds the younger of the two entries.
    assign loadSkid  = accept & mainValid & ~out_ready & ~flush;
    assign clearSkid = flush | (consume & skidValid);

    pipe_slot #(.W(PAY_W)) u_skid (
      .clk   (clk),
      .reset (reset),
      .load  (loadSkid),
      .clear (clearSkid),
      .dIn   (inData),
      .valid (skidValid),
      .dOut  (skidData)
    );

    // Registered ready: depends only on skid occupancy, never on out_ready.
    assign in_ready = ~skidValid;

    // While skid is occupied in_ready=0, so main refills from skid only.
    assign mainIn   = skidValid ? skidData : inData;
    assign loadMain = ~flush &
                      ((accept & (~mainValid | out_ready)) | (consume & skidValid));
  end else begin : g_single
    assign in_ready = ~mainValid | out_ready;
    assign mainIn   = inData;
    assign loadMain = accept & ~flush;
  end

  // Main empties when its entry leaves and nothing replaces it.
  assign clearMain = flush | (consume & ~loadMain);

  // Bubble presentation: NOP opcode and zero dst so M performs no writeback.
  // NOTE: every combinational output gets a default first so no path through
  // this block can infer a latch.
  always_comb begin
    outData    = '0;
    outData.op = NOP_OP;
    if (mainValid) outData = mainData;
  end

  assign out_valid = mainValid;
  assign out_op    = outData.op;
  assign out_valE  = outData.valE;
  assign out_valA  = outData.valA;
  assign out_dstE  = outData.dstE;
  assign out_dstM  = outData.dstM;

  // Saturating idle-cycle counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!mainValid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_m_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_m_stage_pipe
// Three instances share clk/reset:
//   0: SKID_EN=1, CNT_W=16   1: SKID_EN=0, CNT_W=16   2: SKID_EN=1, CNT_W=3
// The reference model treats each instance as a small FIFO (capacity 2 with
// skid, 1 without) plus an integer idle counter. Inputs are driven on the
// falling edge; outputs are compared 1ns later.
// -----------------------------------------------------------------------------
module tb_m_stage_pipe;
  import m_stage_pipe_pkg::*;

  typedef logic [79:0] pay_t;
  typedef logic [97:0] vec_t;

  logic clk = 1'b0;
  logic reset;

  logic [2:0]       flush, inValid, outReady, outValid, inReady;
  logic [2:0][5:0]  inOp, outOp;
  logic [2:0][31:0] inValE, inValA, outValE, outValA;
  logic [2:0][4:0]  inDstE, inDstM, outDstE, outDstM;
  logic [15:0]      bc0, bc1;
  logic [2:0]       bc2;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  pay_t       mFifo [3][2];
  int         mCount [3];
  int         mCnt [3];
  logic [2:0] acceptedLast;
  logic       mAcc, mCon;

  always #5 clk = ~clk;

  m_stage_pipe u_skid (
    .clk(clk), .reset(reset), .flush(flush[0]),
    .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_op(inOp[0]), .in_valE(inValE[0]), .in_valA(inValA[0]),
    .in_dstE(inDstE[0]), .in_dstM(inDstM[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_op(outOp[0]), .out_valE(outValE[0]), .out_valA(outValA[0]),
    .out_dstE(outDstE[0]), .out_dstM(outDstM[0]), .bubble_cnt(bc0)
  );

  m_stage_pipe #(.SKID_EN(0)) u_single (
    .clk(clk), .reset(reset), .flush(flush[1]),
    .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_op(inOp[1]), .in_valE(inValE[1]), .in_valA(inValA[1]),
    .in_dstE(inDstE[1]), .in_dstM(inDstM[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_op(outOp[1]), .out_valE(outValE[1]), .out_valA(outValA[1]),
    .out_dstE(outDstE[1]), .out_dstM(outDstM[1]), .bubble_cnt(bc1)
  );

  m_stage_pipe #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .flush(flush[2]),
    .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_op(inOp[2]), .in_valE(inValE[2]), .in_valA(inValA[2]),
    .in_dstE(inDstE[2]), .in_dstM(inDstM[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]),
    .out_op(outOp[2]), .out_valE(outValE[2]), .out_valA(outValA[2]),
    .out_dstE(outDstE[2]), .out_dstM(outDstM[2]), .bubble_cnt(bc2)
  );

  // ---------------------------------------------------------------- model
  function automatic logic mReady(int i);
    if (i == 1) return (mCount[1] == 0) || outReady[1];
    return mCount[i] < 2;
  endfunction

  function automatic int cntMax(int i);
    return (i == 2) ? 7 : 65535;
  endfunction

  function automatic pay_t inPay(int i);
    return {inOp[i], inValE[i], inValA[i], inDstE[i], inDstM[i]};
  endfunction

  function automatic vec_t expVec(int i);
    pay_t p;
    p = (mCount[i] > 0) ? mFifo[i][0] : {6'h3F, 74'd0};
    return {mCount[i] > 0, p, mReady(i), 16'(mCnt[i])};
  endfunction

  function automatic vec_t obsVec(int i);
    logic [15:0] c;
    case (i)
      0:       c = bc0;
      1:       c = bc1;
      default: c = {13'd0, bc2};
    endcase
    return {outValid[i], outOp[i], outValE[i], outValA[i], outDstE[i],
            outDstM[i], inReady[i], c};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mAcc = inValid[i] && mReady(i);
      mCon = (mCount[i] > 0) && outReady[i];
      acceptedLast[i] = 1'b0;
      if (reset) begin
        mCount[i] = 0;
        mCnt[i]   = 0;
      end else begin
        if (mCount[i] == 0 && mCnt[i] < cntMax(i)) mCnt[i]++;
        if (flush[i]) begin
          mCount[i] = 0;
        end else begin
          if (mCon) begin
            mFifo[i][0] = mFifo[i][1];
            mCount[i]--;
          end
          if (mAcc) begin
            mFifo[i][mCount[i]] = inPay(i);
            mCount[i]++;
            acceptedLast[i] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive(input int i, input logic v, input logic [5:0] op,
                       input logic [31:0] e, input logic [31:0] a,
                       input logic [4:0] de, input logic [4:0] dm);
    inValid[i] = v;
    inOp[i]    = op;
    inValE[i]  = e;
    inValA[i]  = a;
    inDstE[i]  = de;
    inDstM[i]  = dm;
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 5'd0);
  endtask

  task automatic driveRand(input int i);
    drive(i, 1'($urandom_range(0, 1)), 6'($urandom), $urandom, $urandom,
          5'($urandom), 5'($urandom));
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obsVec(k) !== expVec(k)) begin
        fails++;
        $display("FAIL reset_state[%0d]: got %h want %h", k, obsVec(k), expVec(k));
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      tests++;
      if (bc0 !== 16'(c + 1)) begin
        fails++;
        $display("FAIL reset_idle_cnt: got %0d want %0d", bc0, c + 1);
      end
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obsVec(k) !== expVec(k)) begin
          fails++;
          $display("FAIL reset_idle[%0d]: got %h want %h", k, obsVec(k), expVec(k));
        end
      end
    end
  endtask

  task automatic test_stream();
    outReady[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      case (c)
        0:       drive(0, 1'b1, IADDI, 32'd3, 32'd3, 5'd3, 5'd3);
        1:       drive(0, 1'b1, ILW, 32'd5, 32'd5, 5'd5, 5'd5);
        default: idle(0);
      endcase
      #1;
      tests++;
      if (obsVec(0) !== expVec(0)) begin
        fails++;
        $display("FAIL stream c%0d: got %h want %h", c, obsVec(0), expVec(0));
      end
      if (c == 1) begin
        tests++;
        if ({outValid[0], outOp[0], outValE[0], outValA[0], outDstE[0], outDstM[0]} !==
            {1'b1, IADDI, 32'd3, 32'd3, 5'd3, 5'd3}) begin
          fails++;
          $display("FAIL stream_addi: got op %h valE %0d want op %h valE 3",
                   outOp[0], outValE[0], IADDI);
        end
      end
      if (c == 2) begin
        tests++;
        if ({outValid[0], outOp[0], outValE[0], outValA[0], outDstE[0], outDstM[0]} !==
            {1'b1, ILW, 32'd5, 32'd5, 5'd5, 5'd5}) begin
          fails++;
          $display("FAIL stream_lw: got op %h valE %0d want op %h valE 5",
                   outOp[0], outValE[0], ILW);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nxt = 1;
    logic presented = 1'b0;
    int got [8];
    int nGot = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (presented && acceptedLast[0]) nxt++;
      outReady[0] = (c >= 4);
      if (nxt <= 3) begin
        drive(0, 1'b1, ISW, 32'(nxt), 32'(nxt * 16), 5'(nxt), 5'(nxt + 8));
        presented = 1'b1;
      end else begin
        idle(0);
        presented = 1'b0;
      end
      #1;
      tests++;
      if (obsVec(0) !== expVec(0)) begin
        fails++;
        $display("FAIL backpressure c%0d: got %h want %h", c, obsVec(0), expVec(0));
      end
      if (c == 3) begin
        tests++;
        if ({inReady[0], outValid[0], outValE[0]} !== {1'b0, 1'b1, 32'd1}) begin
          fails++;
          $display("FAIL bp_full: got ready %b valid %b valE %0d want ready 0 valid 1 valE 1",
                   inReady[0], outValid[0], outValE[0]);
        end
      end
      if (outValid[0] && outReady[0] && nGot < 8) begin
        got[nGot] = int'(outValE[0]);
        nGot++;
      end
    end
    tests++;
    if (nGot != 3 || got[0] != 1 || got[1] != 2 || got[2] != 3) begin
      fails++;
      $display("FAIL bp_order: got n=%0d [%0d %0d %0d] want n=3 [1 2 3]",
               nGot, got[0], got[1], got[2]);
    end
  endtask

  task automatic test_flush();
    // Phase 0..3: fill both slots, flush with an offer of valE=9.
    // Phase 4..6: flush discarding a same-cycle accept.
    // Phase 7..8: flush while empty.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      flush[0] = 1'b0;
      outReady[0] = 1'b0;
      idle(0);
      case (c)
        0: drive(0, 1'b1, IADDI, 32'd7, 32'd7, 5'd7, 5'd7);
        1: drive(0, 1'b1, IADDI, 32'd8, 32'd8, 5'd8, 5'd8);
        2: begin
          flush[0] = 1'b1;
          drive(0, 1'b1, IADDI, 32'd9, 32'd9, 5'd9, 5'd9);
        end
        3: outReady[0] = 1'b1;
        4: drive(0, 1'b1, ILW, 32'd10, 32'd10, 5'd10, 5'd10);
        5: begin
          flush[0] = 1'b1;
          drive(0, 1'b1, ILW, 32'd11, 32'd11, 5'd11, 5'd11);
        end
        7: flush[0] = 1'b1;
        default: outReady[0] = 1'b1;
      endcase
      #1;
      tests++;
      if (obsVec(0) !== expVec(0)) begin
        fails++;
        $display("FAIL flush c%0d: got %h want %h", c, obsVec(0), expVec(0));
      end
      if (c == 3 || c == 6 || c == 8) begin
        tests++;
        if ({outValid[0], outOp[0], outDstE[0], inReady[0]} !==
            {1'b0, 6'h3F, 5'd0, 1'b1}) begin
          fails++;
          $display("FAIL flush_bubble c%0d: got valid %b op %h dstE %0d ready %b want 0 3f 0 1",
                   c, outValid[0], outOp[0], outDstE[0], inReady[0]);
        end
      end
    end
    flush[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      tests++;
      if (outValid[0] !== 1'b0 || outValE[0] === 32'd9) begin
        fails++;
        $display("FAIL flush_drop: got valid %b valE %0d want valid 0", outValid[0], outValE[0]);
      end
    end
  endtask

  task automatic test_noskid();
    int nxt = 1;
    int want = 1;
    logic presented = 1'b0;
    int nGot = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (presented && acceptedLast[1]) nxt++;
      if (c < 15) begin
        outReady[1] = ((c % 3) != 1);
        drive(1, 1'b1, ILW, 32'(nxt), $urandom, 5'($urandom), 5'($urandom));
        presented = 1'b1;
      end else begin
        outReady[1] = 1'b1;
        idle(1);
        presented = 1'b0;
      end
      #1;
      tests++;
      if (obsVec(1) !== expVec(1)) begin
        fails++;
        $display("FAIL noskid c%0d: got %h want %h", c, obsVec(1), expVec(1));
      end
      if (outValid[1] && outReady[1]) begin
        tests++;
        if (outValE[1] !== 32'(want)) begin
          fails++;
          $display("FAIL noskid_order: got valE %0d want %0d", outValE[1], want);
        end
        want++;
        nGot++;
      end
    end
    tests++;
    if (nGot != nxt - 1 || nGot < 5) begin
      fails++;
      $display("FAIL noskid_count: got %0d delivered want %0d", nGot, nxt - 1);
    end
  endtask

  task automatic test_saturate();
    idle(2);
    outReady[2] = 1'b1;
    flush[2] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      tests++;
      if (obsVec(2) !== expVec(2)) begin
        fails++;
        $display("FAIL saturate c%0d: got %h want %h", c, obsVec(2), expVec(2));
      end
    end
    tests++;
    if (bc2 !== 3'd7) begin
      fails++;
      $display("FAIL sat_hold: got %0d want 7", bc2);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (bc2 !== 3'd0) begin
      fails++;
      $display("FAIL sat_reset: got %0d want 0", bc2);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) begin
        driveRand(i);
        outReady[i] = ($urandom_range(0, 3) != 0);
        flush[i]    = ($urandom_range(0, 15) == 0);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (obsVec(i) !== expVec(i)) begin
          fails++;
          $display("FAIL random c%0d[%0d]: got %h want %h", c, i, obsVec(i), expVec(i));
        end
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(i);
      flush[i] = 1'b0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    flush    = '0;
    outReady = '0;
    for (int i = 0; i < 3; i++) idle(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_noskid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/m_stage_pipe.md
Name: m_stage_pipe

Overview:
- Parametrised successor to the Execute→Memory pipeline register.
- Carries op, ALU result (valE), store data (valA) and destination registers (dstE, dstM) from E to M.
- Adds valid/ready flow control, an optional 2-entry skid buffer for a registered in_ready, synchronous flush, bubble injection and a saturating bubble-cycle counter.

Parameters:
- OP_W, 6, opcode width.
- DATA_W, 32, width of valE/valA.
- REG_W, 5, register-index width.
- NOP_OP, 6'h3F, opcode driven on out_op while no valid entry is presented.
- SKID_EN, 1: 1 = two-entry skid mode; 0 = single-entry mode.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; kills all held entries.
- in_valid  in  1  E-stage entry present.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  OP_W  E_op.
- in_valE  in  DATA_W  e_valE.
- in_valA  in  DATA_W  E_valA.
- in_dstE  in  REG_W  E_dstE.
- in_dstM  in  REG_W  E_dstM.
- out_valid  out  1  M-stage entry present.
- out_ready  in  1  M stage consumes this cycle.
- out_op  out  OP_W  M_op.
- out_valE  out  DATA_W  M_valE.
- out_valA  out  DATA_W  M_valA.
- out_dstE  out  REG_W  M_dstE.
- out_dstM  out  REG_W  M_dstM.
- bubble_cnt  out  CNT_W  count of cycles with out_valid=0 since reset.

Behaviour:
- Handshakes:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
- Reset (sync): main and skid valid bits are 0.
  - Outputs after reset: out_valid=0, out_op=NOP_OP, out_valE=0, out_valA=0, out_dstE=0, out_dstM=0, bubble_cnt=0.
  - in_ready=1.
  - Reset overrides flush and any handshake in the same cycle.
- Bubble outputs: whenever out_valid=0, out_op=NOP_OP and all other payload outputs=0. This includes dst=0, so the bubble performs no register writeback.
- Latency: 1 cycle.
  - An entry accepted at edge N appears on the outputs after edge N when the main slot is empty or being consumed.
  - There is no combinational path from in_* to out_*.
- SKID_EN=1:
  - in_ready = !skid_valid. This is a pure register output with no dependence on out_ready.
  - If accept and (main empty or consume): the entry loads main.
  - If accept and main full and no consume: the entry loads skid.
  - If consume and skid_valid: skid moves to main and skid empties. An accept in the same cycle is impossible, since in_ready=0.
  - If consume, no skid and no accept: main empties.
  - Order is preserved strictly FIFO; at most 2 entries are held.
- SKID_EN=0:
  - Single slot; skid logic is absent.
  - in_ready = !out_valid | out_ready (combinational).
  - Accept loads main; otherwise consume empties main.
- flush:
  - At the edge: main_valid=0 and skid_valid=0.
  - An entry accepted in the same cycle is discarded.
  - Outputs show a bubble the next cycle.
  - flush while empty is a no-op.
- bubble_cnt:
  - Increments at each edge where out_valid=0 and reset=0.
  - Saturates at 2^CNT_W-1 and never wraps.
- Stability: held payload is unchanged while out_valid=1 and out_ready=0.

Decomposition:
- Shared opcode defines header: existing instruction opcodes (IROP, IADDI, ILW, ISW, ...) plus a new INOP define. NOP_OP defaults from INOP.
- One natural sub-module, pipe_slot: payload register plus valid bit, with load, clear and data-in ports. Instantiate it as main and, when SKID_EN=1, as skid.

Test Plan:
1. Reset held for 2 cycles, then released with in_valid=0 → out_valid=0, out_op=NOP_OP, all payload 0, in_ready=1; bubble_cnt=1 after the first non-reset edge and increments by 1 per idle edge after that.
2. Streaming with out_ready=1: IADDI/valE=3/valA=3/dstE=3/dstM=3, then ILW/5/5/5/5 on consecutive cycles → each appears on the outputs exactly 1 cycle later, with out_valid=1 throughout.
3. Backpressure with SKID_EN=1: out_ready=0 and 3 entries offered (valE=1,2,3) → entries 1 and 2 held and in_ready falls to 0; entry 3 is held off. With out_ready=1, outputs are 1,2,3 in order with none lost or duplicated.
4. Flush with 2 entries held and in_valid=1 (valE=9) in the same cycle → next cycle out_valid=0, out_op=NOP_OP, out_dstE=0, in_ready=1, and valE=9 never appears.
5. SKID_EN=0 with out_ready toggling 1,0,1 → in_ready tracks !out_valid|out_ready combinationally, and no entry is dropped or duplicated.
6. CNT_W=3 with 10 idle cycles → bubble_cnt saturates at 7 and holds there; reset returns it to 0.
